// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// hazard_stall_ctrl : load-use stall, branch flush and data-memory wait hold
//   control. Optional macro STALL_PERF_CNT_EN adds a stall-cycle counter.
// Revision : 1.0
// ============================================================================
module hazard_stall_ctrl #(
  parameter int REG_ADDR_W          = 5,
  parameter int LOAD_STALL_CYCLES   = 1,
  parameter int BRANCH_FLUSH_CYCLES = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic                  id_uses_rt_i,
  input  logic                  idex_memread_i,
  input  logic [REG_ADDR_W-1:0] idex_rt_i,
  input  logic                  branch_taken_i,
  input  logic                  mem_req_i,
  input  logic                  dmem_ready_i,
  output logic                  pcwrite_o,
  output logic                  ifidwrite_o,
  output logic                  idex_bubble_o,
  output logic                  ifid_flush_o,
  output logic                  pipe_hold_o,
  output logic                  stall_active_o,
  output logic [15:0]           stall_cycles_o
);

  typedef enum logic [1:0] {
    RUN          = 2'd0,
    LOAD_STALL   = 2'd1,
    BRANCH_FLUSH = 2'd2,
    MEM_WAIT     = 2'd3
  } state_e;

  localparam logic [3:0] LS_INIT = 4'(LOAD_STALL_CYCLES - 1);
  localparam logic [3:0] BF_INIT = 4'(BRANCH_FLUSH_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       load_use;
  logic       mem_wait;
  logic       stall_active;

  assign load_use = idex_memread_i && (idex_rt_i != '0) &&
                    ((idex_rt_i == id_rs_i) || (id_uses_rt_i && (idex_rt_i == id_rt_i)));
  assign mem_wait = mem_req_i && !dmem_ready_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // MEM_WAIT is only entered from RUN, so leaving it is the same as evaluating RUN.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pcwrite_o     = 1'b1;
    ifidwrite_o   = 1'b1;
    idex_bubble_o = 1'b0;
    ifid_flush_o  = 1'b0;
    pipe_hold_o   = 1'b0;

    if (mem_wait) begin
      pipe_hold_o = 1'b1;
      pcwrite_o   = 1'b0;
      ifidwrite_o = 1'b0;
      if (state_q == RUN) begin
        state_d = MEM_WAIT;
      end
    end else if (state_q == BRANCH_FLUSH) begin
      ifid_flush_o  = 1'b1;
      idex_bubble_o = 1'b1;
      if (cnt_q <= 4'd1) begin
        state_d = RUN;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end else if (branch_taken_i) begin
      ifid_flush_o  = 1'b1;
      idex_bubble_o = 1'b1;
      if (BRANCH_FLUSH_CYCLES > 1) begin
        state_d = BRANCH_FLUSH;
        cnt_d   = BF_INIT;
      end else begin
        state_d = RUN;
      end
    end else if (state_q == LOAD_STALL) begin
      pcwrite_o     = 1'b0;
      ifidwrite_o   = 1'b0;
      idex_bubble_o = 1'b1;
      if (cnt_q <= 4'd1) begin
        state_d = RUN;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end else if (load_use) begin
      pcwrite_o     = 1'b0;
      ifidwrite_o   = 1'b0;
      idex_bubble_o = 1'b1;
      if (LOAD_STALL_CYCLES > 1) begin
        state_d = LOAD_STALL;
        cnt_d   = LS_INIT;
      end else begin
        state_d = RUN;
      end
    end else begin
      state_d = RUN;
    end

    if (reset_i) begin
      pcwrite_o     = 1'b0;
      ifidwrite_o   = 1'b0;
      idex_bubble_o = 1'b1;
      ifid_flush_o  = 1'b1;
      pipe_hold_o   = 1'b0;
    end
  end

  assign stall_active   = !reset_i && (!pcwrite_o || ifid_flush_o || pipe_hold_o);
  assign stall_active_o = stall_active;

`ifdef STALL_PERF_CNT_EN
  logic [15:0] perf_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      perf_q <= '0;
    end else if (stall_active && (perf_q != 16'hFFFF)) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign stall_cycles_o = perf_q;
`else
  assign stall_cycles_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// tb_hazard_stall_ctrl : self-checking bench, two parameterisations driven in
//   parallel against a remaining-cycles reference model. Revision : 1.0
// ============================================================================
module tb_hazard_stall_ctrl;

  localparam int NI = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, idex_rt = '0;
  logic       id_uses_rt = 1'b0, idex_memread = 1'b0, branch_taken = 1'b0;
  logic       mem_req = 1'b0, dmem_ready = 1'b1;

  logic [NI-1:0] pcw, ifw, bub, fl, hold, act;
  logic [15:0]   sc [NI];

  int total = 0;
  int passed = 0;

  int stall_left [NI];
  int flush_left [NI];
  int nstall [NI];
  int nflush [NI];
  int perf [NI];
  logic [5:0] exp_o [NI];

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(2), .BRANCH_FLUSH_CYCLES(2)) u_dut0 (
    .clk_i(clk), .reset_i(reset), .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt),
    .idex_memread_i(idex_memread), .idex_rt_i(idex_rt), .branch_taken_i(branch_taken),
    .mem_req_i(mem_req), .dmem_ready_i(dmem_ready), .pcwrite_o(pcw[0]), .ifidwrite_o(ifw[0]),
    .idex_bubble_o(bub[0]), .ifid_flush_o(fl[0]), .pipe_hold_o(hold[0]),
    .stall_active_o(act[0]), .stall_cycles_o(sc[0]));

  hazard_stall_ctrl #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(3), .BRANCH_FLUSH_CYCLES(1)) u_dut1 (
    .clk_i(clk), .reset_i(reset), .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt),
    .idex_memread_i(idex_memread), .idex_rt_i(idex_rt), .branch_taken_i(branch_taken),
    .mem_req_i(mem_req), .dmem_ready_i(dmem_ready), .pcwrite_o(pcw[1]), .ifidwrite_o(ifw[1]),
    .idex_bubble_o(bub[1]), .ifid_flush_o(fl[1]), .pipe_hold_o(hold[1]),
    .stall_active_o(act[1]), .stall_cycles_o(sc[1]));

  function automatic int ls_of(int i);
    return (i == 0) ? 2 : 3;
  endfunction

  function automatic int bf_of(int i);
    return (i == 0) ? 2 : 1;
  endfunction

  // {pcwrite, ifidwrite, idex_bubble, ifid_flush, pipe_hold, stall_active}
  function automatic logic [5:0] obs(int i);
    return {pcw[i], ifw[i], bub[i], fl[i], hold[i], act[i]};
  endfunction

  function automatic logic [15:0] exp_sc(int i);
`ifdef STALL_PERF_CNT_EN
    return 16'(perf[i]);
`else
    return 16'd0;
`endif
  endfunction

  // Reference: track bubbles/flushes still owed rather than any state encoding.
  task automatic model_eval();
    bit lu, mw;
    logic [4:0] e;
    lu = idex_memread && (idex_rt != 0) &&
         ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));
    mw = mem_req && !dmem_ready;
    for (int i = 0; i < NI; i++) begin
      nstall[i] = stall_left[i];
      nflush[i] = flush_left[i];
      if (reset)                   e = 5'b00110;
      else if (mw)                 e = 5'b00001;
      else if (flush_left[i] > 0) begin e = 5'b11110; nflush[i] = flush_left[i] - 1; end
      else if (branch_taken)      begin e = 5'b11110; nflush[i] = bf_of(i) - 1; nstall[i] = 0; end
      else if (stall_left[i] > 0) begin e = 5'b00100; nstall[i] = stall_left[i] - 1; end
      else if (lu)                begin e = 5'b00100; nstall[i] = ls_of(i) - 1; end
      else                         e = 5'b11000;
      exp_o[i] = {e, (!reset && (!e[4] || e[1] || e[0]))};
    end
  endtask

  task automatic model_commit();
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        stall_left[i] = 0; flush_left[i] = 0; perf[i] = 0;
      end else begin
        if (exp_o[i][0] && perf[i] < 65535) perf[i] = perf[i] + 1;
        stall_left[i] = nstall[i];
        flush_left[i] = nflush[i];
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic idle_inputs();
    id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 1'b0; idex_memread = 1'b0; idex_rt = 5'd0;
    branch_taken = 1'b0; mem_req = 1'b0; dmem_ready = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    idex_memread = 1'b1; idex_rt = 5'd1;
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      for (int i = 0; i < NI; i++) begin
        total++;
        if (obs(i) !== 6'b001100 || sc[i] !== 16'd0) $display("FAIL reset dut%0d ctrl=%b sc=%0d want ctrl=001100 sc=0", i, obs(i), sc[i]);
        else passed++;
      end
      advance();
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_load_use();
    idle_inputs();
    idex_memread = 1'b1; idex_rt = 5'd8; id_rs = 5'd8;
    for (int c = 0; c < 4; c++) begin
      step();
      for (int i = 0; i < NI; i++) begin
        total++;
        if (obs(i) !== exp_o[i] || sc[i] !== exp_sc(i)) $display("FAIL load_use dut%0d c%0d ctrl=%b sc=%0d want %b sc=%0d", i, c, obs(i), sc[i], exp_o[i], exp_sc(i));
        else passed++;
      end
      total++;
      if (pcw[0] !== (c >= 2) || bub[0] !== (c < 2)) $display("FAIL load_use_len c%0d pcwrite=%b bubble=%b want %b %b", c, pcw[0], bub[0], c >= 2, c < 2);
      else passed++;
      advance();
      idex_memread = 1'b0;
    end
  endtask

  task automatic test_no_hazard_cases();
    idle_inputs();
    idex_memread = 1'b1; idex_rt = 5'd0; id_rs = 5'd0;
    step();
    total++;
    if (pcw !== 2'b11 || act !== 2'b00) $display("FAIL zero_reg pcwrite=%b active=%b want 11 00", pcw, act);
    else passed++;
    advance();
    idex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd3; id_uses_rt = 1'b0;
    step();
    total++;
    if (pcw !== 2'b11 || act !== 2'b00) $display("FAIL rt_unused pcwrite=%b active=%b want 11 00", pcw, act);
    else passed++;
    advance();
    id_uses_rt = 1'b1;
    step();
    for (int i = 0; i < NI; i++) begin
      total++;
      if (obs(i) !== exp_o[i]) $display("FAIL rt_used dut%0d ctrl=%b want %b", i, obs(i), exp_o[i]);
      else passed++;
    end
    advance();
    idle_inputs();
    repeat (3) begin step(); advance(); end
  endtask

  task automatic test_branch_over_lu();
    idle_inputs();
    idex_memread = 1'b1; idex_rt = 5'd8; id_rs = 5'd8; branch_taken = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      for (int i = 0; i < NI; i++) begin
        total++;
        if (obs(i) !== exp_o[i]) $display("FAIL branch dut%0d c%0d ctrl=%b want %b", i, c, obs(i), exp_o[i]);
        else passed++;
      end
      total++;
      if (fl[0] !== (c < 2) || bub[0] !== (c < 2) || pcw[0] !== 1'b1) $display("FAIL branch_len c%0d flush=%b bubble=%b pcwrite=%b want %b %b 1", c, fl[0], bub[0], pcw[0], c < 2, c < 2);
      else passed++;
      advance();
      idle_inputs();
    end
  endtask

  task automatic test_mem_wait_in_stall();
    idle_inputs();
    idex_memread = 1'b1; idex_rt = 5'd8; id_rs = 5'd8;
    for (int c = 0; c < 8; c++) begin
      if (c >= 2 && c <= 5) begin mem_req = 1'b1; dmem_ready = 1'b0; end
      else begin mem_req = 1'b0; dmem_ready = 1'b1; end
      step();
      for (int i = 0; i < NI; i++) begin
        total++;
        if (obs(i) !== exp_o[i]) $display("FAIL memwait dut%0d c%0d ctrl=%b want %b", i, c, obs(i), exp_o[i]);
        else passed++;
      end
      total++;
      if (bub[1] !== (c < 2 || c == 6) || hold[1] !== (c >= 2 && c <= 5) || pcw[1] !== (c == 7))
        $display("FAIL memwait_seq c%0d bubble=%b hold=%b pcwrite=%b want %b %b %b", c, bub[1], hold[1], pcw[1], c < 2 || c == 6, c >= 2 && c <= 5, c == 7);
      else passed++;
      advance();
      idex_memread = 1'b0;
    end
  endtask

  task automatic test_reset_mid_stall();
    idle_inputs();
    idex_memread = 1'b1; idex_rt = 5'd8; id_rs = 5'd8;
    step(); advance();
    idex_memread = 1'b0;
    reset = 1'b1;
    #2;
    for (int i = 0; i < NI; i++) begin
      total++;
      if (obs(i) !== 6'b001100 || sc[i] !== 16'd0) $display("FAIL async_reset dut%0d ctrl=%b sc=%0d want 001100 0", i, obs(i), sc[i]);
      else passed++;
    end
    step(); advance();
    reset = 1'b0;
    step();
    total++;
    if (pcw !== 2'b11 || act !== 2'b00) $display("FAIL after_reset pcwrite=%b active=%b want 11 00", pcw, act);
    else passed++;
    advance();
  endtask

  task automatic test_perf_counter();
    int want;
    idle_inputs();
    idex_memread = 1'b1; idex_rt = 5'd8; id_rs = 5'd8;
    step(); advance();
    idex_memread = 1'b0;
    repeat (3) begin step(); advance(); end
    mem_req = 1'b1; dmem_ready = 1'b0;
    repeat (4) begin step(); advance(); end
    idle_inputs();
    step();
`ifdef STALL_PERF_CNT_EN
    want = 6;
`else
    want = 0;
`endif
    total++;
    if (sc[0] !== 16'(want)) $display("FAIL perf_cnt stall_cycles=%0d want %0d", sc[0], want);
    else passed++;
    for (int i = 0; i < NI; i++) begin
      total++;
      if (sc[i] !== exp_sc(i)) $display("FAIL perf_model dut%0d stall_cycles=%0d want %0d", i, sc[i], exp_sc(i));
      else passed++;
    end
    advance();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset        = ($urandom_range(0, 79) == 0);
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      id_uses_rt   = 1'($urandom_range(0, 1));
      idex_memread = ($urandom_range(0, 2) == 0);
      idex_rt      = 5'($urandom_range(0, 3));
      branch_taken = ($urandom_range(0, 7) == 0);
      mem_req      = ($urandom_range(0, 2) == 0);
      dmem_ready   = 1'($urandom_range(0, 1));
      step();
      for (int i = 0; i < NI; i++) begin
        total++;
        if (obs(i) !== exp_o[i] || sc[i] !== exp_sc(i)) $display("FAIL random dut%0d c%0d ctrl=%b sc=%0d want %b sc=%0d", i, c, obs(i), sc[i], exp_o[i], exp_sc(i));
        else passed++;
      end
      advance();
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      stall_left[i] = 0; flush_left[i] = 0; nstall[i] = 0; nflush[i] = 0; perf[i] = 0;
    end
    test_reset();
    test_load_use();
    test_no_hazard_cases();
    test_branch_over_lu();
    test_mem_wait_in_stall();
    test_reset_mid_stall();
    test_perf_counter();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
